// File: rtl/i2c_target.sv
// I2C target (responder) with an 8-byte register bank shared with the picosoc
// iomem bus. The external controller writes a pointer byte followed by data
// bytes, or reads bytes starting at the current pointer. SDA is open-drain and
// is only ever pulled low (sda_oe = 1). SCL is never stretched.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [2:0]  iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        wr_irq,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_IGNORE
  } state_e;

  state_e      state_q, state_d;

  // Pin synchronisers plus one history stage for edge detection.
  logic        scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic        sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;

  logic [7:0]  shreg_q, shreg_d;     // incoming byte, MSB first
  logic [3:0]  bitcnt_q, bitcnt_d;   // bits shifted in / driven out
  logic        rw_q, rw_d;           // R/W bit of the accepted address
  logic        first_q, first_d;     // next received byte is the pointer
  logic        ack_q, ack_d;         // controller ACKed the byte just sent
  logic [7:0]  txbuf_q, txbuf_d;     // byte being transmitted, frozen at load
  logic [2:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_irq_q, wr_irq_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  regs_q [8];
  logic [7:0]  regs_d [8];

  logic        scl_rise, scl_fall, start_c, stop_c;
  logic        host_acc;
  logic [3:0]  tx_idx;
  logic        unused_addr_lsbs;

  // Byte lanes within a word are selected by wstrb, so the low address bits
  // carry no information.
  assign unused_addr_lsbs = ^iomem_addr[1:0];

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_c  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_c   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign host_acc = iomem_valid & ~ready_q;
  assign tx_idx   = 4'd7 - bitcnt_q;

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign wr_irq      = wr_irq_q;
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

  // State register and all datapath flops, synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      // Synchronisers reset to the idle-bus level so release of reset does not
      // look like a START or STOP.
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
      shreg_q  <= 8'h00;
      bitcnt_q <= 4'd0;
      rw_q     <= 1'b0;
      first_q  <= 1'b0;
      ack_q    <= 1'b0;
      txbuf_q  <= 8'h00;
      ptr_q    <= 3'd0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_irq_q <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      // NOTE: the register bank is a handful of flops (not a RAM macro) and
      // must read back as zero after reset, so it is reset element by element.
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      scl_s1_q <= scl_s1_d;
      scl_s2_q <= scl_s2_d;
      scl_h_q  <= scl_h_d;
      sda_s1_q <= sda_s1_d;
      sda_s2_q <= sda_s2_d;
      sda_h_q  <= sda_h_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      rw_q     <= rw_d;
      first_q  <= first_d;
      ack_q    <= ack_d;
      txbuf_q  <= txbuf_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      wr_irq_q <= wr_irq_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state logic: bus conditions override the byte-level protocol.
  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = S_IDLE;
    end else if (start_c) begin
      state_d = S_ADDR;
    end else if (scl_fall) begin
      unique case (state_q)
        S_ADDR:     if (bitcnt_q == 4'd8)
                      state_d = (shreg_q[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: state_d = rw_q ? S_TX : S_RX;
        S_RX:       if (bitcnt_q == 4'd8) state_d = S_RX_ACK;
        S_RX_ACK:   state_d = S_RX;
        S_TX:       if (bitcnt_q == 4'd8) state_d = S_TX_ACK;
        S_TX_ACK:   state_d = ack_q ? S_TX : S_IGNORE;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output and datapath logic: shift register, SDA drive, register bank and
  // host port. The host write is applied last so it wins a same-byte collision.
  always_comb begin
    // NOTE: every variable gets a default before any branch; without it a
    // path that skips an assignment would infer a latch.
    scl_s1_d = scl_i;
    scl_s2_d = scl_s1_q;
    scl_h_d  = scl_s2_q;
    sda_s1_d = sda_i;
    sda_s2_d = sda_s1_q;
    sda_h_d  = sda_s2_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    rw_d     = rw_q;
    first_d  = first_q;
    ack_d    = ack_q;
    txbuf_d  = txbuf_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    wr_irq_d = 1'b0;
    ready_d  = host_acc;
    rdata_d  = rdata_q;
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];

    if (stop_c) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      sda_oe_d = 1'b0;
      bitcnt_d = 4'd0;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shreg_d  = {shreg_q[6:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            rw_d = shreg_q[0];
            if (shreg_q[7:1] == ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              txbuf_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              bitcnt_d = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              first_d  = 1'b1;
              bitcnt_d = 4'd0;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            shreg_d  = {shreg_q[6:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            bitcnt_d = 4'd0;
            if (first_q) begin
              ptr_d = shreg_q[2:0];
            end else begin
              regs_d[ptr_q] = shreg_q;
              wr_irq_d      = 1'b1;
              ptr_d         = ptr_q + 3'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            first_d  = 1'b0;
            bitcnt_d = 4'd0;
          end
        end
        S_TX: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 3'd1;
            end else begin
              sda_oe_d = ~txbuf_q[tx_idx[2:0]];
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda_s2_q;
          end else if (scl_fall) begin
            if (ack_q) begin
              txbuf_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              bitcnt_d = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default:  sda_oe_d = 1'b0;
      endcase
    end

    // Host port: return the pre-write word, then apply strobed byte writes.
    if (host_acc) begin
      rdata_d = {regs_q[{iomem_addr[2], 2'd3}], regs_q[{iomem_addr[2], 2'd2}],
                 regs_q[{iomem_addr[2], 2'd1}], regs_q[{iomem_addr[2], 2'd0}]};
      for (int i = 0; i < 4; i++) begin
        if (iomem_wstrb[i]) regs_d[{iomem_addr[2], 2'(i)}] = iomem_wdata[8*i +: 8];
      end
    end
  end

endmodule
